// File: rtl/x_corr_sched_pkg.sv
// Shared state encoding and default widths for the
// cross-correlation sweep sequencer.
package x_corr_sched_pkg;

    localparam int def_length              = 5;
    localparam int def_length_counter_bits = 3;
    localparam int def_freq_bins           = 4;
    localparam int def_freq_bits           = 2;
    localparam int def_out_max_bits        = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_STREAM,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/x_corr_sched_peak_tracker.sv
// Captures one bin's x_corr result and keeps the best
// peak of the sweep; earliest bin wins on ties.
module peak_tracker
    import x_corr_sched_pkg::*;
#(
    parameter int out_max_bits        = def_out_max_bits,
    parameter int length_counter_bits = def_length_counter_bits,
    parameter int freq_bits           = def_freq_bits
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           capture,
    input  logic                           update,
    input  logic                           first,
    input  logic [out_max_bits-1:0]        in_max,
    input  logic [length_counter_bits-1:0] in_index,
    input  logic [freq_bits-1:0]           freq,
    output logic [out_max_bits-1:0]        best_max,
    output logic [length_counter_bits-1:0] best_index,
    output logic [freq_bits-1:0]           best_freq
);

    logic [out_max_bits-1:0]        cap_max;
    logic [length_counter_bits-1:0] cap_index;

    // Hold the handshake result, then fold it into best_* on UPDATE
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_max    <= '0;
            cap_index  <= '0;
            best_max   <= '0;
            best_index <= '0;
            best_freq  <= '0;
        end else begin
            if (capture) begin
                cap_max   <= in_max;
                cap_index <= in_index;
            end
            if (update && (first || cap_max > best_max)) begin
                best_max   <= cap_max;
                best_index <= cap_index;
                best_freq  <= freq;
            end
        end
    end

endmodule

// File: rtl/x_corr_sched.sv
// Sweep sequencer: streams one window per frequency bin
// into x_corr and tracks the best peak of the sweep.
module x_corr_sched
    import x_corr_sched_pkg::*;
#(
    parameter int length              = def_length,
    parameter int length_counter_bits = def_length_counter_bits,
    parameter int freq_bins           = def_freq_bins,
    parameter int freq_bits           = def_freq_bits,
    parameter int out_max_bits        = def_out_max_bits
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [freq_bits-1:0]           freq_sel,
    output logic [length_counter_bits-1:0] sample_addr,
    output logic                           xc_m_tvalid,
    input  logic                           xc_s_tready,
    input  logic                           xc_s_tvalid,
    output logic                           xc_m_tready,
    input  logic [out_max_bits-1:0]        xc_out_max,
    input  logic [length_counter_bits-1:0] xc_index,
    output logic [out_max_bits-1:0]        best_max,
    output logic [length_counter_bits-1:0] best_index,
    output logic [freq_bits-1:0]           best_freq,
    output logic                           result_valid
);

    localparam logic [length_counter_bits-1:0] last_addr =
        length_counter_bits'(length - 1);
    localparam logic [freq_bits-1:0] last_bin =
        freq_bits'(freq_bins - 1);

    state_t state, state_n;
    logic   last_xfer;
    logic   last_freq;

    assign last_xfer = xc_s_tready && (sample_addr == last_addr);
    assign last_freq = (freq_sel == last_bin);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_n     = state;
        busy        = 1'b0;
        done        = 1'b0;
        xc_m_tvalid = 1'b0;
        xc_m_tready = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_SETTLE;
            end
            S_SETTLE: begin
                busy    = 1'b1;
                state_n = S_STREAM;
            end
            S_STREAM: begin
                busy        = 1'b1;
                xc_m_tvalid = 1'b1;
                if (last_xfer) state_n = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                xc_m_tready = 1'b1;
                if (xc_s_tvalid) state_n = S_UPDATE;
            end
            S_UPDATE: begin
                busy    = 1'b1;
                state_n = last_freq ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bin counter, sample address and result flag
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_sel     <= '0;
            sample_addr  <= '0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        freq_sel     <= '0;
                        result_valid <= 1'b0;
                    end
                end
                S_SETTLE: sample_addr <= '0;
                S_STREAM: begin
                    if (last_xfer)
                        sample_addr <= '0;
                    else if (xc_s_tready)
                        sample_addr <= sample_addr + 1'b1;
                end
                S_UPDATE: begin
                    if (last_freq)
                        result_valid <= 1'b1;
                    else
                        freq_sel <= freq_sel + 1'b1;
                end
                default: ;
            endcase
        end
    end

    peak_tracker #(
        .out_max_bits        (out_max_bits),
        .length_counter_bits (length_counter_bits),
        .freq_bits           (freq_bits)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .capture    (state == S_WAIT && xc_s_tvalid),
        .update     (state == S_UPDATE),
        .first      (freq_sel == '0),
        .in_max     (xc_out_max),
        .in_index   (xc_index),
        .freq       (freq_sel),
        .best_max   (best_max),
        .best_index (best_index),
        .best_freq  (best_freq)
    );

endmodule
